// File: rtl/subtrator_pkg.sv
// Shared definitions for the subtractor family and its bit-serial inverse adder.
package subtrator_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_e;

    // Result is trustworthy when the carries into and out of the MSB agree.
    function automatic logic ovf_ok(input logic c_in_msb, input logic c_out_msb);
        return !(c_in_msb ^ c_out_msb);
    endfunction

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder used as the serial datapath slice.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/somador_serial_duv.sv
// Bit-serial signed adder, LSB first, one operand pair per handshake.
// flag=1 means the wrapped sum is exact; flag=0 reports signed overflow.
module somador_serial_duv
    import subtrator_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    serial_state_e    state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_s;
    logic             bit_c;

    full_adder_1b u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    assign in_ready = (state_q == IDLE);
    assign busy     = !in_ready;

    // sum doubles as the result shift register; it is only meaningful once out_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum       <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    sum     <= {bit_s, sum[WIDTH-1:1]};
                    carry_q <= bit_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        flag      <= ovf_ok(carry_q, bit_c);
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_somador_serial_duv.sv
// Self-checking bench for somador_serial_duv against an integer-arithmetic reference.
module tb_somador_serial_duv;

    localparam int unsigned W = 4;
    localparam int MAX_LAT = 3 * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         flag;
    logic         busy;

    int errors = 0;
    int checks = 0;

    somador_serial_duv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flag      (flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: exact integer sum, wrapped to W bits; flag says it fits the signed range.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] s, output logic f);
        int sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx + sy;
        s  = r[W-1:0];
        f  = (r >= -(1 <<< (W - 1))) && (r < (1 <<< (W - 1)));
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one handshake and drains the result; lat counts edges from accept to out_valid.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          output logic [W-1:0] got_sum, output logic got_flag, output int lat);
        int guard = 0;
        while (!in_ready && guard < MAX_LAT) begin
            cycle();
            guard++;
        end
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < MAX_LAT) begin
            cycle();
            lat++;
        end
        got_sum   = sum;
        got_flag  = flag;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== '0 || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ir=%b busy=%b sum=%h flag=%b, expected 0 1 0 0 0",
                     out_valid, in_ready, busy, sum, flag);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ov=%b ir=%b busy=%b, expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{4'd3, 4'd7, 4'h8, 4'hD, 4'hC};
        logic [W-1:0] vb [5] = '{4'd2, 4'd1, 4'hF, 4'd3, 4'hC};
        logic [W-1:0] vs [5] = '{4'd5, 4'h8, 4'd7, 4'd0, 4'h8};
        logic         vf [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] gs;
        logic         gf;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], gs, gf, lat);
            checks++;
            if (gs !== vs[i] || gf !== vf[i] || lat != W) begin
                errors++;
                $display("FAIL directed_%0d: got sum=%h flag=%b lat=%0d, expected sum=%h flag=%b lat=%0d",
                         i, gs, gf, lat, vs[i], vf[i], W);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [W-1:0] gs;
        logic         gf;
        logic [W-1:0] d;
        logic [W-1:0] yv;
        int           lat;
        int           diff;
        for (int x = -(1 << (W - 1)); x < (1 << (W - 1)); x++) begin
            for (int y = -(1 << (W - 1)); y < (1 << (W - 1)); y++) begin
                diff = x - y;
                if (diff >= -(1 << (W - 1)) && diff < (1 << (W - 1))) begin
                    d  = diff[W-1:0];
                    yv = y[W-1:0];
                    run_op(d, yv, gs, gf, lat);
                    checks++;
                    if (gs !== x[W-1:0] || gf !== 1'b1 || lat != W) begin
                        errors++;
                        $display("FAIL round_trip x=%0d y=%0d: got sum=%h flag=%b lat=%0d, expected sum=%h flag=1",
                                 x, y, gs, gf, lat, x[W-1:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, gs, es;
        logic         gf, ef;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            model(ra, rb, es, ef);
            run_op(ra, rb, gs, gf, lat);
            checks++;
            if (gs !== es || gf !== ef || lat != W) begin
                errors++;
                $display("FAIL random a=%h b=%h: got sum=%h flag=%b lat=%0d, expected sum=%h flag=%b",
                         ra, rb, gs, gf, lat, es, ef);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s0, es;
        logic         f0, ef;
        int           lat = 0;
        model(4'd6, 4'hE, es, ef);
        a        = 4'd6;
        b        = 4'hE;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        while (!out_valid && lat < MAX_LAT) begin
            cycle();
            lat++;
        end
        s0 = sum;
        f0 = flag;
        checks++;
        if (s0 !== es || f0 !== ef || lat != W) begin
            errors++;
            $display("FAIL bp_result: got sum=%h flag=%b lat=%0d, expected sum=%h flag=%b lat=%0d",
                     s0, f0, lat, es, ef, W);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (sum !== s0 || flag !== f0 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got sum=%h flag=%b ir=%b ov=%b, expected sum=%h flag=%b ir=0 ov=1",
                         i, sum, flag, in_ready, out_valid, s0, f0);
            end
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_hold_in_valid();
        int lat = 0;
        a        = 4'd1;
        b        = 4'd2;
        in_valid = 1'b1;
        cycle();
        a = 4'd5;
        b = 4'd6;
        while (!out_valid && lat < MAX_LAT) begin
            cycle();
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (sum !== 4'd3 || flag !== 1'b1 || lat != W) begin
            errors++;
            $display("FAIL hold_in_valid: got sum=%h flag=%b lat=%0d, expected sum=3 flag=1 lat=%0d",
                     sum, flag, lat, W);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        cycle();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_capture: got ir=%b busy=%b ov=%b, expected 1 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] gs, es;
        logic         gf, ef;
        int           lat;
        int           spurious = 0;
        a        = 4'd3;
        b        = 4'd2;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: got ov=%b ir=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            cycle();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d cycles with ov=1 or ir=0, expected 0", spurious);
        end
        model(4'd2, 4'h9, es, ef);
        run_op(4'd2, 4'h9, gs, gf, lat);
        checks++;
        if (gs !== es || gf !== ef || lat != W) begin
            errors++;
            $display("FAIL mid_reset_next_op: got sum=%h flag=%b lat=%0d, expected sum=%h flag=%b",
                     gs, gf, lat, es, ef);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_trip();
        test_random();
        test_backpressure();
        test_hold_in_valid();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
